// File: rtl/vram_port_arbiter_if.sv
// Requester/VRAM-side bundle of the VRAM port arbiter.
// The master modport is the requester/testbench side; the slave modport is the arbiter.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              i_a_req;
    logic              i_a_cur;
    logic [ADDR_W-1:0] i_a_adr;
    logic [DATA_W-1:0] i_a_data;
    logic              o_a_ack;

    logic              i_b_req;
    logic              i_b_cur;
    logic [ADDR_W-1:0] i_b_adr;
    logic [DATA_W-1:0] i_b_data;
    logic              o_b_ack;

    logic              i_clr_start;
    logic              o_clr_busy;

    logic [ADDR_W-1:0] o_vram_adr;
    logic [DATA_W-1:0] o_vram_data;
    logic              o_vram_we;
    logic [ADDR_W-1:0] o_cursor_adr;
    logic              o_cursor_on;

    modport master (
        output i_a_req, i_a_cur, i_a_adr, i_a_data,
        output i_b_req, i_b_cur, i_b_adr, i_b_data,
        output i_clr_start,
        input  o_a_ack, o_b_ack, o_clr_busy,
        input  o_vram_adr, o_vram_data, o_vram_we, o_cursor_adr, o_cursor_on
    );

    modport slave (
        input  i_a_req, i_a_cur, i_a_adr, i_a_data,
        input  i_b_req, i_b_cur, i_b_adr, i_b_data,
        input  i_clr_start,
        output o_a_ack, o_b_ack, o_clr_busy,
        output o_vram_adr, o_vram_data, o_vram_we, o_cursor_adr, o_cursor_on
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter sharing the VRAM write port and cursor registers between
// two requesters, with a built-in clear-screen fill sequencer.
module vram_port_arbiter #(
    parameter int                ADDR_W       = 12,
    parameter int                DATA_W       = 8,
    parameter int                SCREEN_CELLS = 2000,
    parameter logic [DATA_W-1:0] FILL_CHAR    = 8'h20
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    vram_port_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, CLEAR} state_e;

    typedef struct packed {
        logic              cur;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
    } req_t;

    localparam logic [ADDR_W:0]   CELLS = (ADDR_W+1)'(SCREEN_CELLS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(SCREEN_CELLS-1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rr_q, rr_d;          // 1: B has priority on a tie
    logic [1:0]        ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] vadr_q, vadr_d;
    logic [DATA_W-1:0] vdata_q, vdata_d;
    logic [ADDR_W-1:0] cadr_q, cadr_d;
    logic              con_q, con_d;

    req_t [1:0] req;
    logic [1:0] req_vld, elig, gnt;
    req_t       sel;
    logic       in_range;

    assign req[0]  = {bus.i_a_cur, bus.i_a_adr, bus.i_a_data};
    assign req[1]  = {bus.i_b_cur, bus.i_b_adr, bus.i_b_data};
    assign req_vld = {bus.i_b_req, bus.i_a_req};

    // A requester whose ack is showing this cycle is still holding the old transaction.
    assign elig     = req_vld & ~ack_q;
    assign gnt[0]   = elig[0] & (~elig[1] | ~rr_q);
    assign gnt[1]   = elig[1] & (~elig[0] |  rr_q);
    assign sel      = gnt[1] ? req[1] : req[0];
    assign in_range = ({1'b0, sel.adr} < CELLS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        ack_d   = '0;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        vadr_d  = vadr_q;
        vdata_d = vdata_q;
        cadr_d  = cadr_q;
        con_d   = con_q;
        case (state_q)
            IDLE: begin
                // busy_q is still high for the final clear write; a new start is ignored then.
                if (bus.i_clr_start && !busy_q) begin
                    we_d    = 1'b1;
                    vadr_d  = '0;
                    vdata_d = FILL_CHAR;
                    cadr_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = ADDR_W'(1);
                    state_d = (LAST == '0) ? IDLE : CLEAR;
                end else if (|gnt) begin
                    ack_d = gnt;
                    rr_d  = gnt[0];
                    if (!sel.cur) begin
                        if (in_range) begin
                            we_d    = 1'b1;
                            vadr_d  = sel.adr;
                            vdata_d = sel.data;
                        end
                    end else begin
                        con_d = sel.data[0];
                        if (in_range) cadr_d = sel.adr;
                    end
                end
            end
            CLEAR: begin
                we_d    = 1'b1;
                vadr_d  = cnt_q;
                vdata_d = FILL_CHAR;
                busy_d  = 1'b1;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            vadr_q  <= '0;
            vdata_q <= '0;
            cadr_q  <= '0;
            con_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            vadr_q  <= vadr_d;
            vdata_q <= vdata_d;
            cadr_q  <= cadr_d;
            con_q   <= con_d;
        end
    end

    assign bus.o_a_ack      = ack_q[0];
    assign bus.o_b_ack      = ack_q[1];
    assign bus.o_clr_busy   = busy_q;
    assign bus.o_vram_we    = we_q;
    assign bus.o_vram_adr   = vadr_q;
    assign bus.o_vram_data  = vdata_q;
    assign bus.o_cursor_adr = cadr_q;
    assign bus.o_cursor_on  = con_q;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed self-checking bench for vram_port_arbiter: inputs driven and
// outputs sampled on the falling edge.
module tb_vram_port_arbiter;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 i_clk = ~i_clk;

    vram_port_arbiter_if #(.ADDR_W(12), .DATA_W(8)) u_if ();

    vram_port_arbiter #(
        .ADDR_W(12), .DATA_W(8), .SCREEN_CELLS(2000), .FILL_CHAR(8'h20)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (u_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        u_if.i_a_req = 1'b0; u_if.i_a_cur = 1'b0; u_if.i_a_adr = '0; u_if.i_a_data = '0;
        u_if.i_b_req = 1'b0; u_if.i_b_cur = 1'b0; u_if.i_b_adr = '0; u_if.i_b_data = '0;
        u_if.i_clr_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_adr [8];
        int ia, ib, nw, first_c, last_c;
        int nclr, bad, busy_cnt, prev_adr;
        logic got, found, seen_busy;

        exp_adr = '{12'd1, 12'd101, 12'd2, 12'd102, 12'd3, 12'd103, 12'd4, 12'd104};
        idle_inputs();

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_we",    32'(u_if.o_vram_we), 0);
        check("rst_adr",   32'(u_if.o_vram_adr), 0);
        check("rst_acks",  32'({u_if.o_b_ack, u_if.o_a_ack}), 0);
        check("rst_busy",  32'(u_if.o_clr_busy), 0);
        check("rst_cur",   32'({u_if.o_cursor_on, u_if.o_cursor_adr}), 0);
        i_rst_n = 1'b1;

        // Single A char write
        @(negedge i_clk);
        u_if.i_a_req = 1'b1; u_if.i_a_adr = 12'h005; u_if.i_a_data = 8'h41;
        @(negedge i_clk);
        check("a_wr_we",   32'(u_if.o_vram_we), 1);
        check("a_wr_adr",  32'(u_if.o_vram_adr), 32'h005);
        check("a_wr_data", 32'(u_if.o_vram_data), 32'h41);
        check("a_wr_ack",  32'(u_if.o_a_ack), 1);
        check("a_wr_back", 32'(u_if.o_b_ack), 0);
        u_if.i_a_req = 1'b0;
        @(negedge i_clk);
        check("a_wr_done", 32'({u_if.o_vram_we, u_if.o_a_ack}), 0);

        // Both requesters streaming from a fresh pointer: A,B,A,B...
        do_reset();
        ia = 0; ib = 0; nw = 0; first_c = -1; last_c = -1;
        u_if.i_a_req = 1'b1; u_if.i_a_adr = 12'd1;   u_if.i_a_data = 8'd1;
        u_if.i_b_req = 1'b1; u_if.i_b_adr = 12'd101; u_if.i_b_data = 8'd101;
        for (int c = 0; c < 14; c++) begin
            @(negedge i_clk);
            if (u_if.o_vram_we) begin
                if (nw < 8) begin
                    check("rr_adr", 32'(u_if.o_vram_adr), 32'(exp_adr[nw]));
                    check("rr_ack", 32'({u_if.o_b_ack, u_if.o_a_ack}), (nw % 2 == 0) ? 32'b01 : 32'b10);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                nw++;
            end
            if (u_if.o_a_ack) begin
                ia++;
                if (ia == 4) u_if.i_a_req = 1'b0;
                else begin u_if.i_a_adr = 12'(ia + 1); u_if.i_a_data = 8'(ia + 1); end
            end
            if (u_if.o_b_ack) begin
                ib++;
                if (ib == 4) u_if.i_b_req = 1'b0;
                else begin u_if.i_b_adr = 12'(101 + ib); u_if.i_b_data = 8'(101 + ib); end
            end
        end
        check("rr_count", 32'(nw), 8);
        check("rr_span",  32'(last_c - first_c), 7);

        // B cursor set, then out-of-range cursor set
        u_if.i_b_req = 1'b1; u_if.i_b_cur = 1'b1; u_if.i_b_adr = 12'h7CF; u_if.i_b_data = 8'h01;
        @(negedge i_clk);
        check("cur_adr", 32'(u_if.o_cursor_adr), 32'h7CF);
        check("cur_on",  32'(u_if.o_cursor_on), 1);
        check("cur_we",  32'(u_if.o_vram_we), 0);
        check("cur_ack", 32'(u_if.o_b_ack), 1);
        u_if.i_b_req = 1'b0;
        @(negedge i_clk);
        u_if.i_b_req = 1'b1; u_if.i_b_adr = 12'h7D0; u_if.i_b_data = 8'h00;
        @(negedge i_clk);
        check("cur_oor_on",  32'(u_if.o_cursor_on), 0);
        check("cur_oor_adr", 32'(u_if.o_cursor_adr), 32'h7CF);
        check("cur_oor_ack", 32'(u_if.o_b_ack), 1);
        u_if.i_b_req = 1'b0; u_if.i_b_cur = 1'b0;
        @(negedge i_clk);

        // A char write to adr 2000 is dropped
        u_if.i_a_req = 1'b1; u_if.i_a_cur = 1'b0; u_if.i_a_adr = 12'd2000; u_if.i_a_data = 8'h7E;
        @(negedge i_clk);
        check("oor_ack", 32'(u_if.o_a_ack), 1);
        check("oor_we",  32'(u_if.o_vram_we), 0);
        check("oor_adr", 32'(u_if.o_vram_adr), 32'd104);
        u_if.i_a_req = 1'b0;
        @(negedge i_clk);

        // Clear with a simultaneous pending A request
        u_if.i_clr_start = 1'b1;
        u_if.i_a_req = 1'b1; u_if.i_a_adr = 12'h010; u_if.i_a_data = 8'h55;
        nclr = 0; bad = 0; busy_cnt = 0; prev_adr = -1; got = 1'b0; seen_busy = 1'b0;
        for (int c = 0; c < 2100; c++) begin
            @(negedge i_clk);
            u_if.i_clr_start = 1'b0;
            if (u_if.o_clr_busy) begin
                if (!seen_busy) check("clr_cur_adr", 32'(u_if.o_cursor_adr), 0);
                seen_busy = 1'b1;
                busy_cnt++;
            end
            if (u_if.o_a_ack) begin
                got = 1'b1;
                check("clr_ack_busy", 32'(u_if.o_clr_busy), 0);
                check("clr_ack_we",   32'(u_if.o_vram_we), 1);
                check("clr_ack_adr",  32'(u_if.o_vram_adr), 32'h010);
                check("clr_ack_data", 32'(u_if.o_vram_data), 32'h55);
                check("clr_prev_adr", 32'(prev_adr), 32'd1999);
                u_if.i_a_req = 1'b0;
                break;
            end
            if (u_if.o_vram_we) begin
                if (u_if.o_vram_adr == 12'(nclr) && u_if.o_vram_data == 8'h20) nclr++;
                else bad++;
                prev_adr = 32'(u_if.o_vram_adr);
            end
        end
        check("clr_ack_seen", 32'(got), 1);
        check("clr_writes",   32'(nclr), 2000);
        check("clr_bad",      32'(bad), 0);
        check("clr_busy_len", 32'(busy_cnt), 2000);
        check("clr_cur_on",   32'(u_if.o_cursor_on), 0);
        @(negedge i_clk);

        // Reset in the middle of a clear
        u_if.i_a_req = 1'b1; u_if.i_a_cur = 1'b1; u_if.i_a_adr = 12'h100; u_if.i_a_data = 8'h01;
        @(negedge i_clk);
        u_if.i_a_req = 1'b0; u_if.i_a_cur = 1'b0;
        check("pre_rst_on", 32'(u_if.o_cursor_on), 1);
        @(negedge i_clk);
        u_if.i_clr_start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 700; c++) begin
            @(negedge i_clk);
            u_if.i_clr_start = 1'b0;
            if (u_if.o_vram_we && u_if.o_vram_adr == 12'd500) begin found = 1'b1; break; end
        end
        check("mid_clr_500", 32'(found), 1);
        i_rst_n = 1'b0;
        #1;
        check("arst_we",   32'(u_if.o_vram_we), 0);
        check("arst_busy", 32'(u_if.o_clr_busy), 0);
        check("arst_vram", 32'({u_if.o_vram_adr, u_if.o_vram_data}), 0);
        check("arst_cur",  32'({u_if.o_cursor_on, u_if.o_cursor_adr}), 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        nw = 0; busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (u_if.o_vram_we) nw++;
            if (u_if.o_clr_busy) busy_cnt++;
        end
        check("post_rst_we",   32'(nw), 0);
        check("post_rst_busy", 32'(busy_cnt), 0);
        u_if.i_a_req = 1'b1; u_if.i_a_adr = 12'd7; u_if.i_a_data = 8'h37;
        u_if.i_b_req = 1'b1; u_if.i_b_adr = 12'd8; u_if.i_b_data = 8'h38;
        @(negedge i_clk);
        check("tie_adr",  32'(u_if.o_vram_adr), 32'd7);
        check("tie_acks", 32'({u_if.o_b_ack, u_if.o_a_ack}), 32'b01);
        idle_inputs();
        repeat (2) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
